// File: rtl/calc_exec_unit_if.sv
// Operand/opcode request channel and result/flag response channel of the execution unit.
// Purely structural bundle; no logic or storage.
// master drives requests and result-ready; slave (the unit) drives ready, results and flags.
interface calc_exec_unit_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [1:0]         op;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               carry;
  logic               borrow;
  logic               zero;
  logic               err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carry, borrow, zero, err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carry, borrow, zero, err
  );
endinterface

// File: rtl/calc_exec_unit.sv
// 8-bit subtractor: a - b computed as a + ~b + 1.
// Combinational, zero latency.
// No handshake.
module subtractor_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       borrow
);
  logic [8:0] sum;

  // Two's-complement add; a missing carry-out means a < b.
  assign sum    = {1'b0, a} + {1'b0, ~b} + 9'd1;
  assign diff   = sum[7:0];
  assign borrow = ~sum[8];
endmodule

// Single-issue ADD/SUB/MUL execution unit with IDLE/EXEC/DONE handshake FSM.
// Latency: 1 cycle after accept for ADD/SUB/reserved, 8 cycles for MUL (shift-add).
// Backpressure: result held in DONE until out_ready; no new request taken until back in IDLE.
module calc_exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  calc_exec_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [1:0]         op_reg;
  logic [2:0]         iter;
  logic [2*WIDTH-1:0] acc;

  logic [2*WIDTH-1:0] result_q;
  logic               carry_q;
  logic               borrow_q;
  logic               zero_q;
  logic               err_q;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   sub_diff;
  logic               sub_borrow;
  logic [2*WIDTH-1:0] mul_addend;
  logic [2*WIDTH-1:0] mul_next;

  // All arithmetic works on the latched operands so bus changes after accept are harmless.
  assign add_sum = {1'b0, a_reg} + {1'b0, b_reg};

  subtractor_8bit u_sub (
    .a      (a_reg),
    .b      (b_reg),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  // One multiplier bit per EXEC cycle: add the shifted multiplicand when that bit is set.
  assign mul_addend = b_reg[iter] ? ({{WIDTH{1'b0}}, a_reg} << iter) : '0;
  assign mul_next   = acc + mul_addend;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.borrow    = borrow_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

  // Control FSM plus result/flag registers; results only change on the final EXEC edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= '0;
      iter     <= '0;
      acc      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg  <= bus.a;
            b_reg  <= bus.b;
            op_reg <= bus.op;
            acc    <= '0;
            iter   <= '0;
            state  <= EXEC;
          end
        end
        EXEC: begin
          case (op_reg)
            OP_ADD: begin
              result_q <= {{(WIDTH-1){1'b0}}, add_sum};
              carry_q  <= add_sum[WIDTH];
              borrow_q <= 1'b0;
              zero_q   <= (add_sum == '0);
              err_q    <= 1'b0;
              state    <= DONE;
            end
            OP_SUB: begin
              result_q <= {{WIDTH{1'b0}}, sub_diff};
              carry_q  <= 1'b0;
              borrow_q <= sub_borrow;
              zero_q   <= (sub_diff == '0);
              err_q    <= 1'b0;
              state    <= DONE;
            end
            OP_MUL: begin
              if (iter == 3'd7) begin
                result_q <= mul_next;
                carry_q  <= 1'b0;
                borrow_q <= 1'b0;
                zero_q   <= (mul_next == '0);
                err_q    <= 1'b0;
                iter     <= '0;
                state    <= DONE;
              end else begin
                acc  <= mul_next;
                iter <= iter + 3'd1;
              end
            end
            default: begin
              result_q <= '0;
              carry_q  <= 1'b0;
              borrow_q <= 1'b0;
              zero_q   <= 1'b1;
              err_q    <= 1'b1;
              state    <= DONE;
            end
          endcase
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/calc_exec_unit.md
CALC_EXEC_UNIT -- requirements
Module: calc_exec_unit

Interface
REQ-001 Parameter: WIDTH, 8, operand width; 8 is the only supported value.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 IN_VALID  input  1  operand/opcode bundle valid.
REQ-005 IN_READY  output  1  unit can accept a bundle; high only in IDLE.
REQ-006 A  input  8  operand A, unsigned.
REQ-007 B  input  8  operand B, unsigned.
REQ-008 OP  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 reserved.
REQ-009 OUT_VALID  output  1  RESULT and flags valid.
REQ-010 OUT_READY  input  1  consumer accepts result.
REQ-011 RESULT  output  16  registered result.
REQ-012 CARRY  output  1  ADD carry-out.
REQ-013 BORROW  output  1  SUB borrow (A < B).
REQ-014 ZERO  output  1  RESULT == 16'h0000.
REQ-015 ERR  output  1  reserved opcode received.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, DONE; no other reachable state.
REQ-017 Accept SHALL occur on an edge where IN_VALID && IN_READY; A, B, OP latched internally; IDLE -> EXEC.
REQ-018 IN_VALID while IN_READY low SHALL be ignored; no bundle queued.
REQ-019 A, B, OP changes after accept SHALL have no effect on the in-flight operation.
REQ-020 ADD, SUB, reserved: EXEC SHALL last 1 cycle; OUT_VALID high after edge k+1, where k is the accept edge.
REQ-021 MUL: EXEC SHALL last exactly 8 cycles using a 3-bit iteration counter (0..7), shift-add, one multiplier bit per cycle; OUT_VALID high after edge k+8.
REQ-022 On the final EXEC edge, RESULT and all flags SHALL be registered together; state -> DONE.
REQ-023 ADD: RESULT = {7'b0, CARRY, (A+B)[7:0]}; CARRY = bit 8 of A+B; BORROW = 0.
REQ-024 SUB: computed as A + ~B + 1 through the team's subtractor_8bit; RESULT = {8'b0, (A-B) mod 256}; BORROW = 1 iff A < B; CARRY = 0.
REQ-025 MUL: RESULT = A*B (full 16-bit, unsigned); CARRY = BORROW = 0.
REQ-026 OP=11: RESULT = 0, ERR = 1, ZERO = 1, CARRY = BORROW = 0.
REQ-027 ZERO SHALL reflect the registered RESULT for every opcode.
REQ-028 DONE: RESULT and flags SHALL hold stable while OUT_READY is low, for any number of cycles.
REQ-029 DONE -> IDLE SHALL occur on the edge where OUT_VALID && OUT_READY; OUT_VALID low the following cycle.
REQ-030 RESULT and flags SHALL retain their last values in IDLE; validity is indicated only by OUT_VALID.
REQ-031 No same-edge output-to-input overlap: a new bundle SHALL be accepted no earlier than the cycle after the result handshake.

Reset
REQ-032 RST high SHALL force state IDLE on that edge, from any state, including mid-MUL and DONE; any in-flight operation is discarded and never emitted.
REQ-033 Reset values: IN_READY=1 (IDLE), OUT_VALID=0, RESULT=16'h0000, CARRY=0, BORROW=0, ZERO=0, ERR=0, iteration counter=0.
REQ-034 RST SHALL take priority over IN_VALID and OUT_READY on the same edge.

Verification
REQ-035 ADD A=200, B=100 -> one cycle after accept: OUT_VALID=1, RESULT=16'h012C, CARRY=1, ZERO=0.
REQ-036 SUB A=5, B=10 -> RESULT=16'h00FB, BORROW=1; then SUB A=10, B=10 -> RESULT=16'h0000, ZERO=1, BORROW=0.
REQ-037 MUL A=255, B=255, with A/B randomized during EXEC -> OUT_VALID exactly 8 cycles after accept, RESULT=16'hFE01.
REQ-038 Backpressure: OUT_READY low for 5 cycles in DONE with IN_VALID held high -> RESULT, flags, and OUT_VALID stable; IN_READY=0; no accept occurs; IDLE is re-entered one cycle after OUT_READY rises.
REQ-039 RST pulsed during MUL EXEC cycle 4 -> next cycle IN_READY=1, OUT_VALID=0, all outputs at reset values; no result is ever emitted for that operation.
REQ-040 OP=11, A=7, B=3 -> one cycle after accept: OUT_VALID=1, ERR=1, RESULT=0, ZERO=1; the next ADD clears ERR to 0.
